// File: rtl/prod_acc_pkg.sv
// Shared constants, state encoding and saturating add for the product accumulator.
package prod_acc_pkg;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned PROD_W  = 8;
    localparam int unsigned SAT_W   = 32;

    typedef enum logic {
        ACC_EMPTY = 1'b0,
        ACC_RUN   = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic signed [SAT_W-1:0] val;
        logic                    clamp;
    } sat_res_t;

    // Add two sign-extended operands one bit wider than SAT_W, then clamp to a signed acc_w range.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] sext_prod,
        input int unsigned             acc_w
    );
        logic signed [SAT_W:0] full;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_res_t              res;
        full = (SAT_W+1)'(acc) + (SAT_W+1)'(sext_prod);
        hi   = ((SAT_W+1)'(1) << (acc_w - 1)) - (SAT_W+1)'(1);
        lo   = -hi - (SAT_W+1)'(1);
        res.val   = SAT_W'(full);
        res.clamp = 1'b0;
        if (full > hi) begin
            res.val   = SAT_W'(hi);
            res.clamp = 1'b1;
        end else if (full < lo) begin
            res.val   = SAT_W'(lo);
            res.clamp = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/prod_accumulator_valid_pipe.sv
// Valid delay line matched to the multiplier latency; reports the last tap and whether any bit is set.
module valid_pipe #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic tap,
    output logic any_set
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr <= DEPTH'({sr, din});
        end
    end

    assign tap     = sr[DEPTH-1];
    assign any_set = |sr;

endmodule

// File: rtl/prod_accumulator.sv
// Sums groups of N_TERMS valid multiplier products into a saturated result on a valid/ready register.
module prod_accumulator #(
    parameter int unsigned PROD_W  = prod_acc_pkg::PROD_W,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned MUL_LAT = prod_acc_pkg::MUL_LAT,
    parameter int unsigned N_TERMS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [PROD_W-1:0] prod,
    input  logic                     clr,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic                     sum_sat,
    output logic                     overrun,
    output logic                     busy
);

    import prod_acc_pkg::*;

    localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    logic                    pvalid;
    logic                    pipe_busy;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic                    grp_sat;

    acc_state_e              state_c;
    sat_res_t                add_c;
    logic signed [ACC_W-1:0] next_acc_c;
    logic                    next_sat_c;
    logic                    complete_c;
    logic                    unused_hi_c;

    valid_pipe #(
        .DEPTH (MUL_LAT)
    ) u_vpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .din     (in_valid),
        .tap     (pvalid),
        .any_set (pipe_busy)
    );

    // Next running value: first term of a group starts fresh, later terms saturate-add.
    always_comb begin
        state_c    = (cnt == '0) ? ACC_EMPTY : ACC_RUN;
        add_c      = sat_add(SAT_W'(acc), SAT_W'(prod), ACC_W);
        next_acc_c = ACC_W'(add_c.val);
        next_sat_c = grp_sat | add_c.clamp;
        if (state_c == ACC_EMPTY) begin
            next_acc_c = ACC_W'(prod);
            next_sat_c = 1'b0;
        end
        complete_c = pvalid && (cnt == LAST);
    end

    // Clamped values always fit ACC_W; the wider bits are sign copies.
    assign unused_hi_c = ^add_c.val[SAT_W-1:ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            grp_sat   <= 1'b0;
            sum       <= '0;
            sum_valid <= 1'b0;
            sum_sat   <= 1'b0;
            overrun   <= 1'b0;
        end else if (clr) begin
            cnt       <= '0;
            acc       <= '0;
            grp_sat   <= 1'b0;
            sum_valid <= 1'b0;
            sum_sat   <= 1'b0;
            overrun   <= 1'b0;
        end else if (complete_c) begin
            // Completion wins over a same-cycle transfer so sum_valid stays high.
            sum       <= next_acc_c;
            sum_sat   <= next_sat_c;
            sum_valid <= 1'b1;
            if (sum_valid && !sum_ready) begin
                overrun <= 1'b1;
            end
            cnt     <= '0;
            acc     <= '0;
            grp_sat <= 1'b0;
        end else begin
            if (pvalid) begin
                acc     <= next_acc_c;
                grp_sat <= next_sat_c;
                cnt     <= cnt + CNT_W'(1);
            end
            if (sum_valid && sum_ready) begin
                sum_valid <= 1'b0;
            end
        end
    end

    assign busy = pipe_busy || (cnt != '0);

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator with a 4-cycle multiplier model and an expected-result queue.
module tb_prod_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic              clr;
    logic              sum_ready;
    logic signed [7:0] a_prod;
    logic signed [7:0] prod;
    logic signed [7:0] mpipe [4];

    logic [11:0] sum;
    logic        sum_valid, sum_sat, overrun, busy;
    logic [8:0]  sum9;
    logic        sum_valid9, sum_sat9, overrun9, busy9;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [11:0] s;
        logic        sat;
    } exp_t;
    exp_t exp_q[$];

    // Multiplier stand-in: product appears MUL_LAT cycles after its operands.
    always @(posedge clk) begin
        mpipe[0] <= a_prod;
        mpipe[1] <= mpipe[0];
        mpipe[2] <= mpipe[1];
        mpipe[3] <= mpipe[2];
    end
    assign prod = mpipe[3];

    prod_accumulator #(.PROD_W(8), .ACC_W(12), .MUL_LAT(4), .N_TERMS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .prod(prod), .clr(clr),
        .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_sat(sum_sat),
        .overrun(overrun), .busy(busy)
    );

    prod_accumulator #(.PROD_W(8), .ACC_W(9), .MUL_LAT(4), .N_TERMS(4)) dut9 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .prod(prod), .clr(clr),
        .sum(sum9), .sum_valid(sum_valid9), .sum_ready(sum_ready), .sum_sat(sum_sat9),
        .overrun(overrun9), .busy(busy9)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int v, input logic sat);
        exp_t e;
        e.s   = 12'(v);
        e.sat = sat;
        exp_q.push_back(e);
    endtask

    task automatic send(input int p);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_prod   = 8'(p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid9();
        int n;
        n = 0;
        while (sum_valid9 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dut9_valid", 32'(sum_valid9), 32'd1);
    endtask

    // Scoreboard: every accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && clr === 1'b0 && sum_valid === 1'b1 && sum_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_sum", 32'(sum), 32'(e.s));
                check("sb_sat", 32'(sum_sat), 32'(e.sat));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        clr       = 1'b0;
        sum_ready = 1'b1;
        a_prod    = '0;
        repeat (2) @(negedge clk);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_valid", 32'(sum_valid), 32'd0);
        check("rst_sat", 32'(sum_sat), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Basic group of 6s: result exactly 5 cycles after the last in_valid, for one cycle.
        repeat (4) send(6);
        push_exp(24, 1'b0);
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            check($sformatf("basic_valid_c%0d", j), 32'(sum_valid), 32'(j == 5));
            if (j == 0) check("basic_busy", 32'(busy), 32'd1);
            if (j == 5) begin
                check("basic_sum", 32'(sum), 32'd24);
                check("basic_sat", 32'(sum_sat), 32'd0);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end

        // Negative group followed back-to-back by a mixed group summing to zero.
        repeat (4) send(-8);
        push_exp(-32, 1'b0);
        send(7); send(-3); send(0); send(-4);
        push_exp(0, 1'b0);
        idle(8);

        // Saturation on the 9-bit instance; the 12-bit instance stays in range.
        repeat (4) send(127);
        push_exp(508, 1'b0);
        idle(1);
        wait_valid9();
        check("sat_pos_sum", 32'(sum9), 32'h0FF);
        check("sat_pos_flag", 32'(sum_sat9), 32'd1);
        repeat (4) send(-128);
        push_exp(-512, 1'b0);
        idle(1);
        wait_valid9();
        check("sat_neg_sum", 32'(sum9), 32'h100);
        check("sat_neg_flag", 32'(sum_sat9), 32'd1);
        idle(6);

        // Backpressure: second group overwrites the first and sets overrun.
        sum_ready = 1'b0;
        repeat (4) send(1);
        repeat (4) send(2);
        push_exp(8, 1'b0);
        idle(8);
        @(negedge clk);
        check("ovr_sum", 32'(sum), 32'd8);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(sum_valid), 32'd1);
        @(posedge clk); #1; sum_ready = 1'b1;
        @(posedge clk); #1; sum_ready = 1'b0;
        @(negedge clk);
        check("ovr_valid_after_xfer", 32'(sum_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        @(negedge clk);
        check("clr_overrun", 32'(overrun), 32'd0);
        check("clr_sum_hold", 32'(sum), 32'd8);
        check("clr_valid", 32'(sum_valid), 32'd0);

        // Accept the pending result in the same cycle the next group completes.
        repeat (4) send(3);
        push_exp(12, 1'b0);
        repeat (4) send(5);
        push_exp(20, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            #1;
            if (j == 1) in_valid = 1'b0;
            if (j == 4) sum_ready = 1'b1;
        end
        @(posedge clk); #1; sum_ready = 1'b0;
        @(negedge clk);
        check("same_valid", 32'(sum_valid), 32'd1);
        check("same_sum", 32'(sum), 32'd20);
        check("same_overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1; sum_ready = 1'b1;
        idle(3);

        // Reset mid-group: partial group and in-flight valids vanish.
        send(9);
        send(9);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(sum_valid), 32'd0);
        check("rst_mid_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) send(5);
        push_exp(20, 1'b0);
        idle(8);
        @(negedge clk);
        check("end_busy", 32'(busy), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
